// File: rtl/frame_stream_tx_pkg.sv
// Shared definitions for the pixel stream transmit path: FSM encodings, pixel layout, width helpers.
package frame_stream_tx_pkg;

   localparam int PIX_W = 24;
   localparam int CH_W  = 8;

   // Channel index = byte position inside the pixel, highest index in the MSBs
   localparam int CH_B = 0;
   localparam int CH_G = 1;
   localparam int CH_R = 2;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACTIVE = 2'd1;
   localparam logic [1:0] HBLANK = 2'd2;
   localparam logic [1:0] VBLANK = 2'd3;

   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic logic [PIX_W-1:0] pix_rgb(input logic [CH_W-1:0] r,
                                                input logic [CH_W-1:0] g,
                                                input logic [CH_W-1:0] b);
      logic [PIX_W-1:0] p;
      p = '0;
      p[CH_R*CH_W +: CH_W] = r;
      p[CH_G*CH_W +: CH_W] = g;
      p[CH_B*CH_W +: CH_W] = b;
      return p;
   endfunction

endpackage

// File: rtl/frame_stream_tx_blank_timer.sv
// Down-counter for line/frame blanking: start loads the count, done pulses on the last blank cycle.
// Latency: done is high in the load-th cycle after start; no backpressure.
module frame_stream_tx_blank_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] load,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= load;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign done = (cnt == W'(1));

endmodule

// File: rtl/frame_stream_tx.sv
// Drains a 1-cycle-latency pixel FIFO into WIDTH*HEIGHT-pixel frames with line and frame blanking.
// Latency: fifo_rd_en -> dst_valid two edges; no backpressure, reads stall only while fifo_empty.
module frame_stream_tx
   import frame_stream_tx_pkg::*;
#(
   parameter int WIDTH   = 1920,
   parameter int HEIGHT  = 1080,
   parameter int H_BLANK = 16,
   parameter int V_BLANK = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             fifo_empty,
   output logic             fifo_rd_en,
   input  logic [PIX_W-1:0] fifo_rd_data,
   output logic             dst_valid,
   output logic [PIX_W-1:0] dst_data,
   output logic             dst_last,
   output logic             busy
);

   localparam int XW        = cnt_w(WIDTH);
   localparam int YW        = cnt_w(HEIGHT);
   localparam int BLANK_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
   localparam int BW        = cnt_w(BLANK_MAX + 1);

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          line_end;
   logic          frame_end;
   logic          tmr_start;
   logic [BW-1:0] tmr_load;
   logic          tmr_done;
   logic          s1_vld;
   logic          s1_last;

   assign line_end   = (x == XW'(WIDTH - 1));
   assign frame_end  = line_end && (y == YW'(HEIGHT - 1));
   assign fifo_rd_en = (state == ACTIVE) && !fifo_empty;

   always_comb begin
      state_nxt = state;
      tmr_start = 1'b0;
      tmr_load  = '0;
      case (state)
         IDLE: begin
            if (enable) state_nxt = ACTIVE;
         end
         ACTIVE: begin
            if (fifo_rd_en && line_end) begin
               if (frame_end) begin
                  state_nxt = VBLANK;
                  tmr_start = 1'b1;
                  tmr_load  = BW'(V_BLANK);
               end else if (H_BLANK != 0) begin
                  state_nxt = HBLANK;
                  tmr_start = 1'b1;
                  tmr_load  = BW'(H_BLANK);
               end
            end
         end
         HBLANK: begin
            if (tmr_done) state_nxt = ACTIVE;
         end
         VBLANK: begin
            if (tmr_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   frame_stream_tx_blank_timer #(
      .W (BW)
   ) u_blank_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .start (tmr_start),
      .load  (tmr_load),
      .done  (tmr_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         x     <= '0;
         y     <= '0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         if ((state == IDLE) && enable) begin
            x    <= '0;
            y    <= '0;
            busy <= 1'b1;
         end else if (fifo_rd_en) begin
            if (line_end) begin
               x <= '0;
               y <= frame_end ? '0 : y + YW'(1);
            end else begin
               x <= x + XW'(1);
            end
         end
         if ((state == VBLANK) && tmr_done) busy <= 1'b0;
      end
   end

   // Stage 1 lines up with the FIFO's read latency; stage 2 captures the returned pixel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld    <= 1'b0;
         s1_last   <= 1'b0;
         dst_valid <= 1'b0;
         dst_data  <= '0;
         dst_last  <= 1'b0;
      end else begin
         s1_vld    <= fifo_rd_en;
         s1_last   <= fifo_rd_en && frame_end;
         dst_valid <= s1_vld;
         dst_last  <= s1_last;
         if (s1_vld) dst_data <= fifo_rd_data;
      end
   end

endmodule
